// File: rtl/tq_transpose_buf.sv
// Ping-pong transpose buffer: captures row-pass output one row per beat and
// replays each block column by column for the column pass of the shared 1D core.
module tq_transpose_buf #(
   parameter int unsigned DW    = 16,
   parameter int unsigned LANES = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_row_valid,
   output logic                o_row_ready,
   input  logic                i_size,
   input  logic [LANES*DW-1:0] i_row_data,
   output logic                o_col_valid,
   input  logic                i_col_ready,
   output logic [LANES*DW-1:0] o_col_data,
   output logic                o_col_last,
   output logic                o_col_size
);

   localparam int unsigned   IW         = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned   HALF       = LANES / 2;
   localparam logic [IW-1:0] LAST_BIG   = IW'(LANES - 1);
   localparam logic [IW-1:0] LAST_SMALL = IW'(HALF - 1);

   logic [DW-1:0] mem_q [2][LANES][LANES];

   logic [1:0]    full_q, full_d;
   logic [1:0]    size_q, size_d;
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic [IW-1:0] wr_row_q, wr_row_d;
   logic [IW-1:0] rd_col_q, rd_col_d;

   logic wr_fire, wr_size, wr_last;
   logic rd_fire, rd_last;

   // Handshakes; the write side sees i_size directly on row 0 since it is latched then
   always_comb begin
      o_row_ready = !full_q[wr_bank_q];
      o_col_valid = full_q[rd_bank_q];
      o_col_size  = size_q[rd_bank_q];
      wr_fire     = i_row_valid && o_row_ready;
      wr_size     = (wr_row_q == '0) ? i_size : size_q[wr_bank_q];
      wr_last     = (wr_row_q == (wr_size ? LAST_BIG : LAST_SMALL));
      rd_last     = o_col_valid && (rd_col_q == (o_col_size ? LAST_BIG : LAST_SMALL));
      rd_fire     = o_col_valid && i_col_ready;
      o_col_last  = rd_last;
   end

   // Column mux; unused lanes and the idle bus read as zero
   always_comb begin
      o_col_data = '0;
      for (int unsigned r = 0; r < LANES; r++) begin
         if (o_col_valid && (o_col_size || (r < HALF))) begin
            o_col_data[r*DW +: DW] = mem_q[rd_bank_q][r][rd_col_q];
         end
      end
   end

   // Next state; write and read sides never touch the same bank's flag in one cycle
   always_comb begin
      full_d    = full_q;
      size_d    = size_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wr_row_d  = wr_row_q;
      rd_col_d  = rd_col_q;
      if (wr_fire) begin
         if (wr_row_q == '0) begin
            size_d[wr_bank_q] = i_size;
         end
         if (wr_last) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            wr_row_d          = '0;
         end else begin
            wr_row_d = wr_row_q + IW'(1);
         end
      end
      if (rd_fire) begin
         if (rd_last) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
            rd_col_d          = '0;
         end else begin
            rd_col_d = rd_col_q + IW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q    <= '0;
         size_q    <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_row_q  <= '0;
         rd_col_q  <= '0;
      end else begin
         full_q    <= full_d;
         size_q    <= size_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_row_q  <= wr_row_d;
         rd_col_q  <= rd_col_d;
      end
   end

   // Coefficient storage carries no reset; lanes beyond the block edge are left untouched
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int unsigned c = 0; c < LANES; c++) begin
            if (wr_size || (c < HALF)) begin
               mem_q[wr_bank_q][wr_row_q][c] <= i_row_data[c*DW +: DW];
            end
         end
      end
   end

endmodule

// File: tb/tb_tq_transpose_buf.sv
// Scoreboard bench for tq_transpose_buf: a transpose model predicts column beats
// and handshake levels, a negedge monitor pops and compares.
module tb_tq_transpose_buf;

   localparam int DW    = 16;
   localparam int LANES = 8;
   localparam int BW    = DW * LANES;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_row_valid;
   logic          o_row_ready;
   logic          i_size;
   logic [BW-1:0] i_row_data;
   logic          o_col_valid;
   logic          i_col_ready;
   logic [BW-1:0] o_col_data;
   logic          o_col_last;
   logic          o_col_size;

   tq_transpose_buf #(.DW(DW), .LANES(LANES)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_row_valid (i_row_valid),
      .o_row_ready (o_row_ready),
      .i_size      (i_size),
      .i_row_data  (i_row_data),
      .o_col_valid (o_col_valid),
      .i_col_ready (i_col_ready),
      .o_col_data  (o_col_data),
      .o_col_last  (o_col_last),
      .o_col_size  (o_col_size)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [BW-1:0] data;
      logic          last;
      logic          size;
   } beat_t;

   beat_t       exp_q[$];
   int          pending = 0;
   int          rows_got = 0;
   logic        blk_size;
   logic [DW-1:0] mrows [LANES][LANES];
   int          total = 0;
   int          bad = 0;
   int          rmode = 0;

   task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model + monitor: predicts levels from block counts, transposes complete blocks
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_row_ready", BW'(o_row_ready), BW'(1));
         chk("rst_col_valid", BW'(o_col_valid), BW'(0));
         chk("rst_col_data", o_col_data, '0);
         chk("rst_col_last", BW'(o_col_last), BW'(0));
         chk("rst_col_size", BW'(o_col_size), BW'(0));
         exp_q.delete();
         pending  = 0;
         rows_got = 0;
      end else begin
         logic exp_valid;
         logic exp_ready;
         exp_valid = (pending > 0);
         exp_ready = (pending < 2);
         chk("row_ready", BW'(o_row_ready), BW'(exp_ready));
         chk("col_valid", BW'(o_col_valid), BW'(exp_valid));
         if (!exp_valid) chk("idle_last", BW'(o_col_last), BW'(0));
         if (exp_valid && i_col_ready) begin
            if (exp_q.size() == 0) begin
               chk("scoreboard_empty", BW'(1), BW'(0));
            end else begin
               beat_t b;
               b = exp_q.pop_front();
               chk("col_data", o_col_data, b.data);
               chk("col_last", BW'(o_col_last), BW'(b.last));
               chk("col_size", BW'(o_col_size), BW'(b.size));
               if (b.last) pending--;
            end
         end
         if (i_row_valid && exp_ready) begin
            int n;
            if (rows_got == 0) blk_size = i_size;
            for (int c = 0; c < LANES; c++) mrows[rows_got][c] = i_row_data[c*DW +: DW];
            rows_got++;
            n = blk_size ? 8 : 4;
            if (rows_got == n) begin
               for (int c = 0; c < n; c++) begin
                  beat_t b;
                  b.data = '0;
                  for (int r = 0; r < n; r++) b.data[r*DW +: DW] = mrows[r][c];
                  b.last = (c == n - 1);
                  b.size = blk_size;
                  exp_q.push_back(b);
               end
               pending++;
               rows_got = 0;
            end
         end
      end
   end

   // Column-side ready: 0 = always high, 1 = held low, 2 = random
   initial begin
      i_col_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0:       i_col_ready = 1'b1;
            1:       i_col_ready = 1'b0;
            default: i_col_ready = 1'($urandom);
         endcase
      end
   end

   // kind 0: r*16+c, kind 1: 100+r*4+c with upper lanes FFFF, else random; nrows 0 = whole block
   task automatic send_block(input logic sz, input int kind, input int nrows, input bit gaps);
      int n;
      int rows;
      n    = sz ? 8 : 4;
      rows = (nrows > 0) ? nrows : n;
      for (int r = 0; r < rows; r++) begin
         logic [BW-1:0] d;
         int w;
         for (int c = 0; c < LANES; c++) begin
            logic [DW-1:0] v;
            case (kind)
               0:       v = DW'(r * 16 + c);
               1:       v = (c < 4) ? DW'(100 + r * 4 + c) : 16'hFFFF;
               default: v = DW'($urandom);
            endcase
            d[c*DW +: DW] = v;
         end
         i_row_valid = 1'b1;
         i_row_data  = d;
         i_size      = (r == 0) ? sz : 1'($urandom);
         w = 0;
         @(negedge clk);
         while (!o_row_ready) begin
            w++;
            if (w > 500) begin
               $display("FAIL row_accept_timeout: got stalled expected accept (t=%0t)", $time);
               $fatal(1, "row stall bound expired");
            end
            @(negedge clk);
         end
         @(posedge clk);
         #1;
         if (gaps && ($urandom_range(0, 3) == 0)) begin
            i_row_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      i_row_valid = 1'b0;
      rmode = 0;
      while (pending != 0) begin
         @(posedge clk);
         w++;
         if (w > 300) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got pending=%0d expected 0", pending);
            break;
         end
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      i_row_valid = 1'b0;
      i_size      = 1'b0;
      i_row_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      send_block(1'b1, 0, 0, 1'b0);
      drain();
      send_block(1'b0, 1, 0, 1'b0);
      drain();

      for (int k = 0; k < 5; k++) send_block(1'b1, (k == 0) ? 0 : 2, 0, 1'b0);
      drain();

      // Three blocks against a stalled reader: the third block waits for bank release
      rmode = 1;
      fork
         begin
            for (int k = 0; k < 3; k++) send_block(1'b1, 2, 0, 1'b0);
            i_row_valid = 1'b0;
         end
         begin
            repeat (50) @(posedge clk);
            rmode = 0;
         end
      join
      drain();

      rmode = 2;
      send_block(1'b1, 2, 0, 1'b0);
      send_block(1'b0, 2, 0, 1'b0);
      send_block(1'b1, 2, 0, 1'b0);
      drain();

      // Reset while a block is partly read and another partly written
      rmode = 1;
      send_block(1'b1, 0, 0, 1'b0);
      send_block(1'b0, 2, 3, 1'b0);
      i_row_valid = 1'b0;
      rmode = 0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      send_block(1'b1, 2, 0, 1'b0);
      drain();

      rmode = 2;
      for (int k = 0; k < 12; k++) send_block(1'($urandom), 2, 0, 1'b1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
